// File: rtl/rect_motion_pkg.sv
// ============================================================================
// Module : rect_motion_pkg
// Shared types and constants for the rectangle motion scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rect_motion_pkg;

   localparam int FRAC           = 8;
   localparam int POS_W          = 12;
   localparam int FX_W           = POS_W + FRAC;
   localparam int VISIBLE_HEIGHT = 600;
   localparam int RECT_HEIGHT    = 64;

   typedef enum logic [1:0] {
      FOLLOW = 2'd0,
      FALL   = 2'd1,
      RISE   = 2'd2,
      REST   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rect_motion_sched_edge_det.sv
// ============================================================================
// Module : edge_det
// Registered one-cycle rising-edge strobe; delay register resets to RST_VAL.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise
);

   logic r_d;
   logic r_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d    <= RST_VAL;
         r_rise <= 1'b0;
      end else begin
         r_d    <= i_sig;
         r_rise <= i_sig & ~r_d;
      end
   end

   assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/rect_motion_sched.sv
// ============================================================================
// Module : rect_motion_sched
// Per-frame motion scheduler: follow mouse, fall, damped bounce, rest.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rect_motion_sched #(
   parameter int FLOOR_Y      = rect_motion_pkg::VISIBLE_HEIGHT - rect_motion_pkg::RECT_HEIGHT,
   parameter int FRAC         = rect_motion_pkg::FRAC,
   parameter int GRAVITY      = 64,
   parameter int DAMP_SHIFT   = 2,
   parameter int MIN_BOUNCE_V = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic [1:0]  state,
   output logic [7:0]  bounce_cnt
);

   import rect_motion_pkg::*;

   localparam int           W          = 12 + FRAC;
   localparam logic [W-1:0] c_FLOOR_FX = W'(FLOOR_Y) << FRAC;
   localparam logic [W:0]   c_GRAV     = (W+1)'(GRAVITY);
   localparam logic [W:0]   c_MIN_V    = (W+1)'(MIN_BOUNCE_V);

   logic         w_tick;
   logic         w_press;
   state_t       r_state;
   logic [11:0]  r_xpos;
   logic [W-1:0] r_y_fx;
   logic [W-1:0] r_vel;
   logic [7:0]   r_bc;

   logic [W-1:0] w_my_fx;
   logic [W:0]   w_vel_g;
   logic [W+1:0] w_yn;
   logic [W:0]   w_vd;
   logic [W-1:0] w_vr;
   logic         w_hit;
   logic [7:0]   w_bc_inc;

   edge_det #(.RST_VAL(1'b1)) u_vsync_edge (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (vsync),
      .o_rise (w_tick)
   );

   edge_det #(.RST_VAL(1'b1)) u_press_edge (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (mouse_left),
      .o_rise (w_press)
   );

   // Sums carry extra headroom so floor/overflow tests see the true value.
   assign w_my_fx  = {mouse_ypos, {FRAC{1'b0}}};
   assign w_vel_g  = {1'b0, r_vel} + c_GRAV;
   assign w_yn     = {2'b00, r_y_fx} + {1'b0, w_vel_g};
   assign w_vd     = w_vel_g - (w_vel_g >> DAMP_SHIFT);
   assign w_vr     = r_vel - W'(GRAVITY);
   assign w_hit    = (w_yn >= {2'b00, c_FLOOR_FX});
   assign w_bc_inc = (r_bc == 8'hFF) ? r_bc : r_bc + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FOLLOW;
         r_xpos  <= '0;
         r_y_fx  <= '0;
         r_vel   <= '0;
         r_bc    <= '0;
      end else begin
         case (r_state)
            FOLLOW: begin
               if (w_press) begin
                  r_xpos <= mouse_xpos;
                  r_vel  <= '0;
                  r_bc   <= '0;
                  if (mouse_ypos >= 12'(FLOOR_Y)) begin
                     r_y_fx  <= c_FLOOR_FX;
                     r_state <= REST;
                  end else begin
                     r_y_fx  <= w_my_fx;
                     r_state <= FALL;
                  end
               end else if (w_tick) begin
                  r_xpos <= mouse_xpos;
                  r_y_fx <= w_my_fx;
               end
            end
            FALL: begin
               if (w_tick) begin
                  if (w_hit) begin
                     r_y_fx <= c_FLOOR_FX;
                     r_bc   <= w_bc_inc;
                     if (w_vd < c_MIN_V) begin
                        r_vel   <= '0;
                        r_state <= REST;
                     end else begin
                        r_vel   <= w_vd[W-1:0];
                        r_state <= RISE;
                     end
                  end else begin
                     r_y_fx <= w_yn[W-1:0];
                     r_vel  <= w_vel_g[W-1:0];
                  end
               end
            end
            RISE: begin
               if (w_tick) begin
                  if (r_vel <= W'(GRAVITY)) begin
                     r_vel   <= '0;
                     r_state <= FALL;
                  end else if (w_vr > r_y_fx) begin
                     // Would pass the top of the screen: pin to row 0.
                     r_y_fx  <= '0;
                     r_vel   <= '0;
                     r_state <= FALL;
                  end else begin
                     r_y_fx <= r_y_fx - w_vr;
                     r_vel  <= w_vr;
                  end
               end
            end
            REST: begin
               if (w_press) begin
                  r_state <= FOLLOW;
               end
            end
            default: r_state <= FOLLOW;
         endcase
      end
   end

   assign xpos       = r_xpos;
   assign ypos       = r_y_fx[FRAC+11:FRAC];
   assign state      = r_state;
   assign bounce_cnt = r_bc;

endmodule

`default_nettype wire

// File: tb/tb_rect_motion_sched.sv
// ============================================================================
// Module : tb_rect_motion_sched
// Directed bench with a reference model feeding an expected-value queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rect_motion_sched;

   localparam int FLOOR_FX = 536 * 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        mouse_left;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic [1:0]  state;
   logic [7:0]  bounce_cnt;

   always #5 clk = ~clk;

   rect_motion_sched dut (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync),
      .mouse_left (mouse_left),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .xpos       (xpos),
      .ypos       (ypos),
      .state      (state),
      .bounce_cnt (bounce_cnt)
   );

   typedef struct {
      string tag;
      int    x;
      int    y;
      int    st;
      int    bc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state (integer arithmetic, Q.8 fixed point)
   int m_x, m_y, m_vel, m_st, m_bc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_x = 0; m_y = 0; m_vel = 0; m_st = 0; m_bc = 0;
   endtask

   task automatic m_tick();
      int v, yn, vd;
      case (m_st)
         0: begin
            m_x = int'(mouse_xpos);
            m_y = int'(mouse_ypos) * 256;
         end
         1: begin
            v  = m_vel + 64;
            yn = m_y + v;
            if (yn >= FLOOR_FX) begin
               m_y  = FLOOR_FX;
               m_bc = (m_bc < 255) ? m_bc + 1 : 255;
               vd   = v - v / 4;
               if (vd < 128) begin m_vel = 0; m_st = 3; end
               else          begin m_vel = vd; m_st = 2; end
            end else begin
               m_y   = yn;
               m_vel = v;
            end
         end
         2: begin
            if (m_vel <= 64) begin
               m_vel = 0; m_st = 1;
            end else begin
               m_vel = m_vel - 64;
               if (m_vel > m_y) begin m_y = 0; m_vel = 0; m_st = 1; end
               else m_y = m_y - m_vel;
            end
         end
         default: ;
      endcase
   endtask

   task automatic m_press();
      case (m_st)
         0: begin
            m_x = int'(mouse_xpos); m_vel = 0; m_bc = 0;
            if (int'(mouse_ypos) >= 536) begin m_y = FLOOR_FX; m_st = 3; end
            else begin m_y = int'(mouse_ypos) * 256; m_st = 1; end
         end
         3: m_st = 0;
         default: ;
      endcase
   endtask

   task automatic push_model(input string tag);
      exp_t e;
      e.tag = tag; e.x = m_x; e.y = m_y / 256; e.st = m_st; e.bc = m_bc;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".xpos"},  32'(xpos),       32'(e.x));
      chk({e.tag, ".ypos"},  32'(ypos),       32'(e.y));
      chk({e.tag, ".state"}, 32'(state),      32'(e.st));
      chk({e.tag, ".bcnt"},  32'(bounce_cnt), 32'(e.bc));
   endtask

   // Event strobes fire one clk after the rise; outputs one clk later.
   task automatic do_event(input string tag, input bit tick, input bit prs);
      @(negedge clk);
      vsync      = tick;
      mouse_left = prs;
      if (prs && (m_st == 0 || m_st == 3)) m_press();
      else if (tick) m_tick();
      push_model(tag);
      @(negedge clk);
      @(negedge clk);
      check_out();
      vsync      = 1'b0;
      mouse_left = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int saved_bc;
      int guard;

      // 1: reset with button held and vsync high
      rst = 1'b1; vsync = 1'b1; mouse_left = 1'b1;
      mouse_xpos = 12'd77; mouse_ypos = 12'd88;
      m_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.xpos",  32'(xpos),  32'd0);
      chk("rst.ypos",  32'(ypos),  32'd0);
      chk("rst.bcnt",  32'(bounce_cnt), 32'd0);
      vsync = 1'b0; mouse_left = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rel.xpos",  32'(xpos),  32'd0);
      chk("rst_rel.state", 32'(state), 32'd0);

      // 2: follow
      mouse_xpos = 12'd100; mouse_ypos = 12'd200;
      do_event("follow1", 1'b1, 1'b0);
      chk("follow1.x_const", 32'(xpos), 32'd100);
      chk("follow1.y_const", 32'(ypos), 32'd200);
      mouse_xpos = 12'd150; mouse_ypos = 12'd250;
      repeat (5) @(negedge clk);
      chk("midframe.xpos", 32'(xpos), 32'd100);
      chk("midframe.ypos", 32'(ypos), 32'd200);
      do_event("follow2", 1'b1, 1'b0);

      // 3: drop from (300,500)
      mouse_xpos = 12'd300; mouse_ypos = 12'd500;
      do_event("drop", 1'b0, 1'b1);
      chk("drop.state_const", 32'(state), 32'd1);
      mouse_xpos = 12'd10; mouse_ypos = 12'd10;
      for (int k = 1; k <= 17; k++) begin
         do_event("fall", 1'b1, 1'b0);
         if (k == 1) chk("tick1.ypos", 32'(ypos), 32'd500);
         if (k == 4) chk("tick4.ypos", 32'(ypos), 32'd502);
         if (k == 17) begin
            chk("tick17.ypos",  32'(ypos),       32'd536);
            chk("tick17.bcnt",  32'(bounce_cnt), 32'd1);
            chk("tick17.state", 32'(state),      32'd2);
            chk("tick17.xpos",  32'(xpos),       32'd300);
         end
      end
      // First rise step reveals the damped velocity 816 (rise by 752/256 px)
      do_event("rise1", 1'b1, 1'b0);
      chk("rise1.ypos", 32'(ypos), 32'd533);

      // 4: bounce to rest
      guard = 0;
      while (m_st != 3 && guard < 3000) begin
         do_event("bounce", 1'b1, 1'b0);
         guard++;
      end
      chk("settle.state", 32'(state), 32'd3);
      chk("settle.ypos",  32'(ypos),  32'd536);
      chk("settle.xpos",  32'(xpos),  32'd300);
      saved_bc = m_bc;
      repeat (3) do_event("rest_tick", 1'b1, 1'b0);
      chk("rest.bcnt_stable", 32'(bounce_cnt), 32'(saved_bc));

      // 5: press below floor goes straight to rest
      mouse_xpos = 12'd400; mouse_ypos = 12'd580;
      do_event("rest_exit", 1'b0, 1'b1);
      chk("rest_exit.state", 32'(state), 32'd0);
      do_event("drop580", 1'b0, 1'b1);
      chk("drop580.state", 32'(state),      32'd3);
      chk("drop580.ypos",  32'(ypos),       32'd536);
      chk("drop580.bcnt",  32'(bounce_cnt), 32'd0);
      do_event("rest_exit2", 1'b0, 1'b1);
      mouse_xpos = 12'd50; mouse_ypos = 12'd60;
      do_event("track", 1'b1, 1'b0);
      chk("track.xpos", 32'(xpos), 32'd50);
      chk("track.ypos", 32'(ypos), 32'd60);

      // 6: coincident press+tick in FALL, then reset mid-rise
      mouse_xpos = 12'd200; mouse_ypos = 12'd100;
      do_event("drop2", 1'b0, 1'b1);
      repeat (3) do_event("fall2", 1'b1, 1'b0);
      do_event("coinc", 1'b1, 1'b1);
      chk("coinc.state", 32'(state), 32'd1);
      guard = 0;
      while (m_st != 2 && guard < 200) begin
         do_event("to_rise", 1'b1, 1'b0);
         guard++;
      end
      do_event("rise2", 1'b1, 1'b0);
      chk("rise2.state", 32'(state), 32'd2);
      @(negedge clk);
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      chk("midrst.state", 32'(state),      32'd0);
      chk("midrst.xpos",  32'(xpos),       32'd0);
      chk("midrst.ypos",  32'(ypos),       32'd0);
      chk("midrst.bcnt",  32'(bounce_cnt), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
